// File: rtl/fp_mul_pipe_vr.sv
// Parametrised floating-point multiplier (DAZ/FTZ, five rounding modes) with a 3-stage elastic pipeline.
// Latency: 3 register stages (unpack/classify, multiply, normalise/round/pack); throughput 1 op/clk.
// Backpressure: each stage loads when empty or draining; in_ready ripples combinationally from out_ready.
// Ports: clk/rst (async active-high), flush (sync drop of in-flight ops), in_* operand handshake,
//        out_* result handshake with 5-bit flags {NV, DZ, OF, UF, NX} and passthrough tag.
module fp_mul_pipe_vr #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] in_x,
    input  logic [EXP_W+MAN_W:0] in_y,
    input  logic [2:0]           in_rm,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] out_res,
    output logic [4:0]           out_flags,
    output logic [TAG_W-1:0]     out_tag
);
    localparam int FW = 1 + EXP_W + MAN_W;
    localparam int PW = 2 * MAN_W + 2;
    localparam int EW = EXP_W + 2;

    localparam logic [EW-1:0] BIAS_E = {3'b000, {(EXP_W-1){1'b1}}};
    localparam logic [EW-1:0] EMAX_E = {2'b00, {EXP_W{1'b1}}};
    localparam logic [FW-1:0] QNAN   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    localparam logic [2:0] RM_RTZ = 3'd1;
    localparam logic [2:0] RM_RDN = 3'd2;
    localparam logic [2:0] RM_RUP = 3'd3;
    localparam logic [2:0] RM_RMM = 3'd4;

    // ---------------- handshake ----------------
    logic v1, v2, v3;
    logic ld1, ld2, ld3;

    assign ld3       = !v3 || out_ready;
    assign ld2       = !v2 || ld3;
    assign ld1       = !v1 || ld2;
    assign in_ready  = ld1 && !flush;
    assign out_valid = v3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
        end else if (flush) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
        end else begin
            if (ld1) v1 <= in_valid;
            if (ld2) v2 <= v1;
            if (ld3) v3 <= v2;
        end
    end

    // ---------------- S1: unpack / classify ----------------
    logic             xs, ys;
    logic [EXP_W-1:0] xe, ye;
    logic [MAN_W-1:0] xf, yf;
    logic x_zero, x_inf, x_nan, x_snan;
    logic y_zero, y_inf, y_nan, y_snan;
    logic inv;

    assign {xs, xe, xf} = in_x;
    assign {ys, ye, yf} = in_y;

    // Subnormal inputs count as zero (DAZ), so zero is just a zero exponent.
    assign x_zero = (xe == '0);
    assign y_zero = (ye == '0);
    assign x_inf  = (&xe) && (xf == '0);
    assign y_inf  = (&ye) && (yf == '0);
    assign x_nan  = (&xe) && (xf != '0);
    assign y_nan  = (&ye) && (yf != '0);
    assign x_snan = x_nan && !xf[MAN_W-1];
    assign y_snan = y_nan && !yf[MAN_W-1];
    assign inv    = (x_inf && y_zero) || (y_inf && x_zero);

    logic          c1_spec;
    logic [FW-1:0] c1_res;
    logic          c1_nv;

    always_comb begin
        c1_spec = 1'b0;
        c1_res  = '0;
        c1_nv   = 1'b0;
        if (x_nan || y_nan || inv) begin
            c1_spec = 1'b1;
            c1_res  = QNAN;
            c1_nv   = x_snan || y_snan || inv;
        end else if (x_inf || y_inf) begin
            c1_spec = 1'b1;
            c1_res  = {xs ^ ys, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (x_zero || y_zero) begin
            c1_spec = 1'b1;
            c1_res  = {xs ^ ys, {(FW-1){1'b0}}};
        end
    end

    logic             s1_sign, s1_spec, s1_nv;
    logic [FW-1:0]    s1_spec_res;
    logic [MAN_W:0]   s1_xsig, s1_ysig;
    logic [EXP_W-1:0] s1_xe, s1_ye;
    logic [2:0]       s1_rm;
    logic [TAG_W-1:0] s1_tag;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_sign     <= 1'b0;
            s1_spec     <= 1'b0;
            s1_nv       <= 1'b0;
            s1_spec_res <= '0;
            s1_xsig     <= '0;
            s1_ysig     <= '0;
            s1_xe       <= '0;
            s1_ye       <= '0;
            s1_rm       <= '0;
            s1_tag      <= '0;
        end else if (in_ready && in_valid) begin
            s1_sign     <= xs ^ ys;
            s1_spec     <= c1_spec;
            s1_nv       <= c1_nv;
            s1_spec_res <= c1_res;
            s1_xsig     <= {1'b1, xf};
            s1_ysig     <= {1'b1, yf};
            s1_xe       <= xe;
            s1_ye       <= ye;
            s1_rm       <= in_rm;
            s1_tag      <= in_tag;
        end
    end

    // ---------------- S2: significand multiply + exponent sum ----------------
    logic [PW-1:0] c2_prod;
    logic [EW-1:0] c2_e;

    assign c2_prod = {{(MAN_W+1){1'b0}}, s1_xsig} * {{(MAN_W+1){1'b0}}, s1_ysig};
    // Two extra bits: sign for underflow detection, headroom for overflow.
    assign c2_e    = {2'b00, s1_xe} + {2'b00, s1_ye} - BIAS_E;

    logic             s2_sign, s2_spec, s2_nv;
    logic [FW-1:0]    s2_spec_res;
    logic [PW-1:0]    s2_prod;
    logic [EW-1:0]    s2_e;
    logic [2:0]       s2_rm;
    logic [TAG_W-1:0] s2_tag;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_sign     <= 1'b0;
            s2_spec     <= 1'b0;
            s2_nv       <= 1'b0;
            s2_spec_res <= '0;
            s2_prod     <= '0;
            s2_e        <= '0;
            s2_rm       <= '0;
            s2_tag      <= '0;
        end else if (!flush && ld2 && v1) begin
            s2_sign     <= s1_sign;
            s2_spec     <= s1_spec;
            s2_nv       <= s1_nv;
            s2_spec_res <= s1_spec_res;
            s2_prod     <= c2_prod;
            s2_e        <= c2_e;
            s2_rm       <= s1_rm;
            s2_tag      <= s1_tag;
        end
    end

    // ---------------- S3: normalise / round / pack ----------------
    logic [PW-2:0]  pn;      // product with the leading one removed
    logic [EW-1:0]  e_n, e_r;
    logic [MAN_W-1:0] frac;
    logic           g, st, inc;
    logic [MAN_W:0] mant;
    logic [FW-1:0]  c3_res;
    logic [4:0]     c3_flags;
    logic [FW-1:0]  max_fin, inf_res;

    always_comb begin
        pn       = s2_prod[PW-1] ? s2_prod[PW-2:0] : {s2_prod[PW-3:0], 1'b0};
        e_n      = s2_e + {{(EW-1){1'b0}}, s2_prod[PW-1]};
        frac     = pn[PW-2 -: MAN_W];
        g        = pn[MAN_W];
        st       = |pn[MAN_W-1:0];
        case (s2_rm)
            RM_RTZ:  inc = 1'b0;
            RM_RDN:  inc = s2_sign && (g || st);
            RM_RUP:  inc = !s2_sign && (g || st);
            RM_RMM:  inc = g;
            default: inc = g && (st || frac[0]);   // RNE, also codes 5-7
        endcase
        mant     = {1'b0, frac} + {{MAN_W{1'b0}}, inc};
        // A carry out leaves mant[MAN_W-1:0] all zero, so only the exponent moves.
        e_r      = e_n + {{(EW-1){1'b0}}, mant[MAN_W]};
        max_fin  = {s2_sign, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
        inf_res  = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        c3_res   = {s2_sign, e_r[EXP_W-1:0], mant[MAN_W-1:0]};
        c3_flags = {4'b0000, g || st};

        if (s2_spec) begin
            c3_res   = s2_spec_res;
            c3_flags = {s2_nv, 4'b0000};
        end else if (e_n[EW-1] || (e_n == '0)) begin
            // Flush-to-zero decided on the unrounded exponent.
            c3_res   = {s2_sign, {(FW-1){1'b0}}};
            c3_flags = 5'b00011;
        end else if (e_r >= EMAX_E) begin
            c3_flags = 5'b00101;
            case (s2_rm)
                RM_RTZ:  c3_res = max_fin;
                RM_RDN:  c3_res = s2_sign ? inf_res : max_fin;
                RM_RUP:  c3_res = s2_sign ? max_fin : inf_res;
                default: c3_res = inf_res;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_res   <= '0;
            out_flags <= '0;
            out_tag   <= '0;
        end else if (!flush && ld3 && v2) begin
            out_res   <= c3_res;
            out_flags <= c3_flags;
            out_tag   <= s2_tag;
        end
    end

endmodule

// File: tb/tb_fp_mul_pipe_vr.sv
// Self-checking bench for fp_mul_pipe_vr (fp32 configuration): directed vectors through a
// scoreboard queue popped by a monitor, plus latency, stall/capacity, flush and reset scenarios.
module tb_fp_mul_pipe_vr;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_x = '0;
    logic [31:0] in_y = '0;
    logic [2:0]  in_rm = '0;
    logic [3:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_res;
    logic [4:0]  out_flags;
    logic [3:0]  out_tag;

    fp_mul_pipe_vr #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_y(in_y), .in_rm(in_rm), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_res(out_res), .out_flags(out_flags), .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  flags;
        logic [3:0]  tag;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;
    int acc_cnt = 0;
    int rcv_cnt = 0;
    int lat_n = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Handshake counter (used for capacity / flush acceptance checks).
    always @(posedge clk)
        if (!rst && in_valid && in_ready) acc_cnt++;

    // Monitor: compares each delivered result against the oldest expectation.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            exp_t e;
            rcv_cnt++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_result: got res=%h flags=%h tag=%h, none expected",
                         out_res, out_flags, out_tag);
            end else begin
                e = sb.pop_front();
                if (out_res !== e.res || out_flags !== e.flags || out_tag !== e.tag) begin
                    errors++;
                    $display("FAIL result_tag%0d: got res=%h flags=%h tag=%h expected res=%h flags=%h tag=%h",
                             e.tag, out_res, out_flags, out_tag, e.res, e.flags, e.tag);
                end
            end
        end
    end

    // Called just after a rising edge; returns just after the edge that accepted the op.
    task automatic send(input logic [31:0] x, input logic [31:0] y, input logic [2:0] rm,
                        input logic [3:0] tag, input logic [31:0] eres, input logic [4:0] eflags);
        bit got;
        exp_t e;
        got = 0;
        in_x = x; in_y = y; in_rm = rm; in_tag = tag; in_valid = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (in_ready) begin
                e.res = eres; e.flags = eflags; e.tag = tag;
                sb.push_back(e);
                got = 1;
                break;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout tag%0d: in_ready stayed 0, expected 1", tag);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 50; i++) begin
            if (sb.size() == 0) break;
            @(posedge clk); #1;
        end
        check("drain_queue_empty", 64'(sb.size()), 64'd0);
    endtask

    // Pipeline must be empty and out_ready high on entry.
    task automatic lat_test(input logic [31:0] x, input logic [31:0] y, input logic [2:0] rm,
                            input logic [3:0] tag, input logic [31:0] eres, input logic [4:0] eflags);
        lat_n = 0;
        fork
            send(x, y, rm, tag, eres, eflags);
            begin
                for (int i = 0; i < 20; i++) begin
                    @(posedge clk); #1;
                    lat_n++;
                    if (out_valid) break;
                end
            end
        join
        check("latency", 64'(lat_n), 64'd3);
        drain();
    endtask

    task automatic fill3(input logic [3:0] t0);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            send(32'h3FC00000, 32'h40000000, 3'd0, t0 + 4'(i), 32'h40400000, 5'h00);
    endtask

    typedef struct packed {
        logic [31:0] x, y;
        logic [2:0]  rm;
        logic [31:0] res;
        logic [4:0]  flags;
    } vec_t;

    vec_t vecs[20];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, r0;
        //            x             y             rm    res           flags
        vecs[0]  = {32'h7F800000, 32'h00000000, 3'd0, 32'h7FC00000, 5'h10}; // Inf*0
        vecs[1]  = {32'h7FA00000, 32'h3F800000, 3'd0, 32'h7FC00000, 5'h10}; // sNaN
        vecs[2]  = {32'h7FC00000, 32'h3F800000, 3'd0, 32'h7FC00000, 5'h00}; // qNaN
        vecs[3]  = {32'h3F800001, 32'h3F800001, 3'd0, 32'h3F800002, 5'h01}; // RNE
        vecs[4]  = {32'h3F800001, 32'h3F800001, 3'd3, 32'h3F800003, 5'h01}; // RUP
        vecs[5]  = {32'h3F800001, 32'h3F800001, 3'd1, 32'h3F800002, 5'h01}; // RTZ
        vecs[6]  = {32'h7F000000, 32'h7F000000, 3'd0, 32'h7F800000, 5'h05}; // OF RNE
        vecs[7]  = {32'h7F000000, 32'h7F000000, 3'd1, 32'h7F7FFFFF, 5'h05}; // OF RTZ
        vecs[8]  = {32'h00800000, 32'h3F000000, 3'd0, 32'h00000000, 5'h03}; // FTZ
        vecs[9]  = {32'hFF000000, 32'h7F000000, 3'd2, 32'hFF800000, 5'h05}; // OF RDN neg
        vecs[10] = {32'hFF000000, 32'h7F000000, 3'd3, 32'hFF7FFFFF, 5'h05}; // OF RUP neg
        vecs[11] = {32'h7F000000, 32'h7F000000, 3'd2, 32'h7F7FFFFF, 5'h05}; // OF RDN pos
        vecs[12] = {32'h7F000000, 32'h7F000000, 3'd4, 32'h7F800000, 5'h05}; // OF RMM
        vecs[13] = {32'hFF800000, 32'h40000000, 3'd0, 32'hFF800000, 5'h00}; // -Inf*2
        vecs[14] = {32'h7F800000, 32'hFF800000, 3'd0, 32'hFF800000, 5'h00}; // Inf*-Inf
        vecs[15] = {32'h80000000, 32'h3F800000, 3'd0, 32'h80000000, 5'h00}; // -0*1
        vecs[16] = {32'h3FC00000, 32'h3F800003, 3'd0, 32'h3FC00004, 5'h01}; // tie RNE even
        vecs[17] = {32'h3FC00000, 32'h3F800003, 3'd4, 32'h3FC00005, 5'h01}; // tie RMM away
        vecs[18] = {32'h3F800001, 32'h3F800001, 3'd7, 32'h3F800002, 5'h01}; // rm 7 -> RNE
        vecs[19] = {32'h3FFFFFFF, 32'h3F800001, 3'd3, 32'h40000001, 5'h01}; // MSB-set normalise

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_in_ready",  64'(in_ready),  64'd1);
        check("reset_out_res",   64'(out_res),   64'd0);
        check("reset_out_flags", 64'(out_flags), 64'd0);
        check("reset_out_tag",   64'(out_tag),   64'd0);

        // Basic op and latency.
        lat_test(32'h3FC00000, 32'h40000000, 3'd0, 4'd5, 32'h40400000, 5'h00);

        // Directed vectors, back to back.
        for (int i = 0; i < 20; i++)
            send(vecs[i].x, vecs[i].y, vecs[i].rm, 4'(i), vecs[i].res, vecs[i].flags);
        drain();

        // Stall: capacity 3, stable outputs, in-order release.
        a0 = acc_cnt;
        r0 = rcv_cnt;
        out_ready = 1'b0;
        fork
            begin
                send(32'h3FC00000, 32'h40000000, 3'd0, 4'd1, 32'h40400000, 5'h00);
                send(32'h3F800001, 32'h3F800001, 3'd0, 4'd2, 32'h3F800002, 5'h01);
                send(32'h7F000000, 32'h7F000000, 3'd1, 4'd3, 32'h7F7FFFFF, 5'h05);
                send(32'h00800000, 32'h3F000000, 3'd0, 4'd4, 32'h00000000, 5'h03);
                send(32'h80000000, 32'h3F800000, 3'd0, 4'd5, 32'h80000000, 5'h00);
            end
            begin
                repeat (8) @(posedge clk);
                @(negedge clk);
                check("stall_accepts",   64'(acc_cnt - a0), 64'd3);
                check("stall_in_ready",  64'(in_ready),     64'd0);
                check("stall_out_valid", 64'(out_valid),    64'd1);
                check("stall_out_tag",   64'(out_tag),      64'd1);
                check("stall_out_res_a", 64'(out_res),      64'h40400000);
                @(negedge clk);
                check("stall_out_res_b", 64'(out_res),      64'h40400000);
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        drain();
        check("stall_results", 64'(rcv_cnt - r0), 64'd5);

        // Flush with 3 in flight; op presented with flush must be dropped.
        fill3(4'd9);
        in_x = 32'h3FC00000; in_y = 32'h40000000; in_rm = 3'd0; in_tag = 4'd12;
        in_valid = 1'b1;
        flush = 1'b1;
        a0 = acc_cnt;
        @(negedge clk);
        check("flush_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_out_valid", 64'(out_valid), 64'd0);
        check("flush_no_accept", 64'(acc_cnt - a0), 64'd0);
        sb.delete();
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1 check("flush_stays_empty", 64'(out_valid), 64'd0);
        lat_test(32'h40000000, 32'h40000000, 3'd0, 4'd6, 32'h40800000, 5'h00);

        // Asynchronous reset with 3 in flight.
        fill3(4'd1);
        #2 rst = 1'b1;
        #1;
        check("rst_out_valid_immediate", 64'(out_valid), 64'd0);
        check("rst_out_res", 64'(out_res), 64'd0);
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        lat_test(32'h3F800001, 32'h3F800001, 3'd3, 4'd7, 32'h3F800003, 5'h01);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
